// File: rtl/irq_vector_ctl_pkg.sv
// Shared interrupt definitions for all bus-request level controllers:
// handshake state encoding and the default spurious vector.
package irq_vector_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } irq_state_e;

  localparam logic [8:0] DEF_SPUR_VEC = 9'o000;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder. It is shared by the level
// controllers. idx_o is zero when nothing is requesting.
module irq_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic         found_o,
  output logic [2:0]   idx_o
);

  // The scan runs downward, so the lowest requesting index is written last and wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        found_o = 1'b1;
        idx_o   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/irq_vector_ctl.sv
// Vectored interrupt responder for one bus-request level. It latches request
// edges, drives a level irq, and answers the processor's vector strobe.
module irq_vector_ctl
  import irq_vector_ctl_pkg::*;
#(
  parameter int         NSRC     = 4,
  parameter logic [8:0] SPUR_VEC = DEF_SPUR_VEC
) (
  input  logic              clk_p,
  input  logic              bus_reset,
  input  logic [NSRC-1:0]   src_req,
  input  logic [9*NSRC-1:0] src_vec,
  output logic [NSRC-1:0]   src_ack,
  output logic              irq_o,
  input  logic              istb_i,
  output logic [8:0]        ivec_o,
  output logic              iack_o
);

  irq_state_e      state_q;
  logic [NSRC-1:0] req_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [2:0]      sel_q;
  logic            spur_q;
  logic [8:0]      ivec_q;
  logic            iack_q;
  logic [NSRC-1:0] src_ack_q;

  logic [8:0]      vec_arr [NSRC];
  logic            win_found;
  logic [2:0]      win_idx;
  logic [8:0]      win_vec;
  logic [NSRC-1:0] req_rise;
  logic [NSRC-1:0] ack_clr;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_vec
    assign vec_arr[gi] = src_vec[9*gi +: 9];
  end

  irq_prio_enc #(.N(NSRC)) u_prio (
    .req_i   (pending_q),
    .found_o (win_found),
    .idx_o   (win_idx)
  );

  always_comb begin
    win_vec = SPUR_VEC;
    for (int i = 0; i < NSRC; i++) begin
      if (win_found && win_idx == 3'(i)) win_vec = vec_arr[i];
    end
  end

  // A new edge overrides a same-cycle acknowledge clear, so the source is not lost.
  always_comb begin
    req_rise  = src_req & ~req_q;
    ack_clr   = (state_q == ST_ACK && !spur_q) ? (NSRC'(1) << sel_q) : '0;
    pending_d = (pending_q & src_req & ~ack_clr) | req_rise;
  end

  always_ff @(posedge clk_p) begin
    if (bus_reset) begin
      req_q     <= '0;
      pending_q <= '0;
    end else begin
      req_q     <= src_req;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk_p) begin
    if (bus_reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= 3'd0;
      spur_q    <= 1'b0;
      ivec_q    <= 9'd0;
      iack_q    <= 1'b0;
      src_ack_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (istb_i) begin
            sel_q     <= win_idx;
            spur_q    <= ~win_found;
            ivec_q    <= win_vec;
            iack_q    <= 1'b1;
            src_ack_q <= win_found ? (NSRC'(1) << win_idx) : '0;
            state_q   <= ST_ACK;
          end
        end
        ST_ACK: begin
          iack_q    <= 1'b0;
          src_ack_q <= '0;
          state_q   <= ST_HOLD;
        end
        ST_HOLD: begin
          // A strobe still held high is never answered twice.
          if (!istb_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign irq_o   = |pending_q;
  assign ivec_o  = ivec_q;
  assign iack_o  = iack_q;
  assign src_ack = src_ack_q;

endmodule

// File: tb/tb_irq_vector_ctl.sv
// Directed bench for irq_vector_ctl: single source, priority, withdrawal,
// held strobe, reset mid-handshake and coincident set/clear.
module tb_irq_vector_ctl;

  localparam int NSRC = 4;

  logic              clk_p = 1'b0;
  logic              bus_reset;
  logic [NSRC-1:0]   src_req;
  logic [9*NSRC-1:0] src_vec;
  logic [NSRC-1:0]   src_ack;
  logic              irq_o;
  logic              istb_i;
  logic [8:0]        ivec_o;
  logic              iack_o;

  int vectors    = 0;
  int miscompares = 0;

  irq_vector_ctl #(.NSRC(NSRC), .SPUR_VEC(9'o000)) dut (
    .clk_p     (clk_p),
    .bus_reset (bus_reset),
    .src_req   (src_req),
    .src_vec   (src_vec),
    .src_ack   (src_ack),
    .irq_o     (irq_o),
    .istb_i    (istb_i),
    .ivec_o    (ivec_o),
    .iack_o    (iack_o)
  );

  always #5 clk_p = ~clk_p;

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Full strobe handshake from IDLE, ending back in IDLE.
  task automatic grant(input string tag, input logic [8:0] exp_vec, input logic [3:0] exp_ack);
    istb_i = 1'b1;
    tick();
    chk({tag, ".ivec"}, 16'(ivec_o), 16'(exp_vec));
    chk({tag, ".iack"}, 16'(iack_o), 16'd1);
    chk({tag, ".src_ack"}, 16'(src_ack), 16'(exp_ack));
    tick();
    chk({tag, ".iack_end"}, 16'(iack_o), 16'd0);
    chk({tag, ".src_ack_end"}, 16'(src_ack), 16'd0);
    chk({tag, ".ivec_hold"}, 16'(ivec_o), 16'(exp_vec));
    istb_i = 1'b0;
    tick();
  endtask

  initial begin
    int iack_cnt;
    bus_reset = 1'b1;
    src_req   = '0;
    istb_i    = 1'b0;
    src_vec   = {9'o070, 9'o060, 9'o064, 9'o100};
    tick();
    tick();
    bus_reset = 1'b0;
    chk("reset.irq", 16'(irq_o), 16'd0);
    chk("reset.iack", 16'(iack_o), 16'd0);
    chk("reset.ivec", 16'(ivec_o), 16'd0);
    chk("reset.src_ack", 16'(src_ack), 16'd0);

    // Single source
    src_req = 4'b0100;
    tick();
    chk("single.irq_up", 16'(irq_o), 16'd1);
    grant("single", 9'o060, 4'b0100);
    chk("single.irq_down", 16'(irq_o), 16'd0);

    // Priority: sources 3 and 1 on the same edge
    src_req = '0;
    tick();
    src_req = 4'b1010;
    tick();
    chk("prio.irq_up", 16'(irq_o), 16'd1);
    grant("prio1", 9'o064, 4'b0010);
    chk("prio.irq_still", 16'(irq_o), 16'd1);
    grant("prio2", 9'o070, 4'b1000);
    chk("prio.irq_down", 16'(irq_o), 16'd0);

    // Withdraw before strobe gives a spurious vector
    src_req = '0;
    tick();
    src_req = 4'b0001;
    tick();
    chk("wd.irq_up", 16'(irq_o), 16'd1);
    src_req = 4'b0000;
    tick();
    chk("wd.irq_down", 16'(irq_o), 16'd0);
    grant("wd.spur", 9'o000, 4'b0000);

    // Held strobe: exactly one acknowledge across 10 cycles
    src_req = 4'b0110;
    tick();
    istb_i   = 1'b1;
    iack_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (iack_o === 1'b1) iack_cnt++;
    end
    chk("held.iack_count", 16'(iack_cnt), 16'd1);
    chk("held.ivec1", 16'(ivec_o), 16'(9'o064));
    chk("held.irq", 16'(irq_o), 16'd1);
    istb_i = 1'b0;
    tick();
    grant("held2", 9'o060, 4'b0100);
    chk("held.irq_down", 16'(irq_o), 16'd0);

    // Reset during the ACK cycle
    src_req = '0;
    tick();
    src_req = 4'b1000;
    tick();
    istb_i = 1'b1;
    tick();
    chk("rst.iack_pre", 16'(iack_o), 16'd1);
    bus_reset = 1'b1;
    tick();
    chk("rst.iack", 16'(iack_o), 16'd0);
    chk("rst.src_ack", 16'(src_ack), 16'd0);
    chk("rst.irq", 16'(irq_o), 16'd0);
    chk("rst.ivec", 16'(ivec_o), 16'd0);
    bus_reset = 1'b0;
    // Strobe still high: pending is empty when sampled, so spurious; the held
    // request posts on the same edge since req_d was cleared.
    tick();
    chk("rst.spur_ivec", 16'(ivec_o), 16'd0);
    chk("rst.spur_iack", 16'(iack_o), 16'd1);
    chk("rst.spur_src_ack", 16'(src_ack), 16'd0);
    chk("rst.repost_irq", 16'(irq_o), 16'd1);
    tick();
    istb_i = 1'b0;
    tick();
    grant("rst.repost", 9'o070, 4'b1000);
    chk("rst.irq_down", 16'(irq_o), 16'd0);

    // Coincident edge and acknowledge clear on the winner
    src_req = '0;
    tick();
    src_req = 4'b0100;
    tick();
    istb_i  = 1'b1;
    src_req = 4'b0000;
    tick();
    chk("coin.ivec", 16'(ivec_o), 16'(9'o060));
    chk("coin.src_ack", 16'(src_ack), 16'b0100);
    src_req = 4'b0100;
    tick();
    chk("coin.irq_set_wins", 16'(irq_o), 16'd1);
    istb_i = 1'b0;
    tick();
    grant("coin.again", 9'o060, 4'b0100);
    chk("coin.irq_down", 16'(irq_o), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/irq_vector_ctl.md
# irq_vector_ctl

Vectored interrupt responder for one bus-request level of the processor board. It collects edge-triggered requests from up to NSRC peripheral sources and drives one level request line (irq_i[n]) toward the processor. When the processor's vector strobe (istb_o[n]) arrives, it arbitrates among pending sources by fixed priority. It then returns the winner's 9-bit vector with a one-cycle acknowledge (ivec / iack_i) and notifies the winning source. It sits between per-device request logic (serial ports, disk controllers) and the processor board's interrupt vector input.

## Interface
- NSRC, 4: number of request sources, 1..8; index 0 has the highest priority.
- SPUR_VEC, 9'o000: vector returned when the strobe arrives with nothing pending.
- clk_p  input  1  system clock; all logic on the rising edge.
- bus_reset  input  1  reset; synchronous, active-high.
- src_req  input  NSRC  per-source request; a rising edge posts an interrupt.
- src_vec  input  9*NSRC  flattened vectors; source i uses bits [9i+8:9i]; treated as static.
- src_ack  output  NSRC  one-cycle pulse to the source whose vector was delivered.
- irq_o  output  1  level request to the processor, high while any source is pending.
- istb_i  input  1  vector strobe from the processor; held high until acknowledged.
- ivec_o  output  9  vector returned to the processor.
- iack_o  output  1  vector acknowledge, one-cycle pulse.

## Operation
- **Edge detect and pending latch.**
  - Register req_d <= src_req.
  - pending[i] is set when src_req[i] & ~req_d[i].
  - pending[i] is cleared when src_req[i] is low (request withdrawn) or when source i is acknowledged.
  - If a set and an acknowledge-clear coincide on the same bit, set wins.
- **irq_o** = |pending. It is combinational from registers, so there is no output glitch.
- **Arbitration.** The winner is the lowest index with pending set. It is evaluated only in IDLE while istb_i is high.
- **FSM.**
  - IDLE: when istb_i = 1, latch the winner index into sel and load ivec_o from the winner's src_vec; if no source is pending, load SPUR_VEC and set the spurious flag. Go to ACK.
  - ACK: iack_o = 1. src_ack[sel] = 1 unless the spurious flag is set. pending[sel] is cleared at the end of this cycle. Go to HOLD.
  - HOLD: wait for istb_i = 0, then go to IDLE. While in HOLD, a high istb_i is never re-acknowledged.
- **Withdrawal after latch.** If the winner withdraws its request after sel is latched, the latched vector is still delivered and src_ack still pulses.
- **New edges.** Edges arriving in ACK or HOLD are posted normally and served on the next strobe.
- **ivec_o** holds its value until the next IDLE grant.
- **Reset values** (one cycle after bus_reset is sampled high; applies at any state, including mid-handshake):
  - pending = 0, req_d = 0, sel = 0, spurious = 0
  - ivec_o = 0, iack_o = 0, src_ack = 0, irq_o = 0
  - state = IDLE
- **After reset.** Because req_d resets to 0, a source holding src_req high when reset is released posts an interrupt.

## Timing
- src_req rises, sampled at edge N: pending and irq_o are high after edge N.
- istb_i sampled high at edge K in IDLE: ivec_o is valid and state is ACK after K. iack_o and src_ack are high for exactly the cycle K..K+1. pending[sel] clears at K+1.
- Acknowledge latency from the strobe is 1 cycle.
- Minimum strobe-to-strobe spacing: the strobe must be low for 1 sampled cycle (HOLD to IDLE), so back-to-back grants are at least 3 cycles apart.
- ivec_o is stable for the whole cycle in which iack_o is high, and remains stable afterward.

## Structure
- The state encoding (IDLE/ACK/HOLD) and the default SPUR_VEC belong in the shared interrupt definitions include, used by all level controllers.
- One sub-module: irq_prio_enc. It is a combinational NSRC-input lowest-index priority encoder with outputs found and idx[2:0], and is reusable by other level controllers.

## Test plan
- **Single source.** Reset, then src_req[2] 0→1 with src_vec[2] = 9'o060. Expect irq_o = 1 the next cycle. Raise istb_i. Expect ivec_o = 9'o060, a single-cycle iack_o one cycle later, a src_ack[2] pulse, and irq_o = 0 after.
- **Priority.** src_req[3] and src_req[1] rise on the same edge (vectors 9'o070, 9'o064). First strobe returns 9'o064 and irq_o stays 1. Second strobe returns 9'o070 and irq_o falls.
- **Withdraw.** src_req[0] rises, then drops before any strobe. Expect pending cleared and irq_o = 0. A strobe then returns SPUR_VEC with iack_o and no src_ack pulse.
- **Held strobe.** Hold istb_i high for 10 cycles with two sources pending. Expect exactly one iack_o. After istb_i drops for 1 cycle and rises again, expect the second vector.
- **Reset mid-handshake.** Assert bus_reset in the ACK cycle. Next cycle expect iack_o = 0, src_ack = 0, irq_o = 0, ivec_o = 0, and a subsequent strobe returning SPUR_VEC.
- **Coincident events.** The acknowledged source's src_req falls and rises in the ACK cycle. Expect its pending to end set (set wins) and irq_o to remain 1.
